// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter and its sibling
// read-side scheduler.
package fifo_arb_pkg;

    localparam int unsigned DEF_BITSIZE   = 8;
    localparam int unsigned DEF_NUM_REQ   = 4;
    localparam int unsigned DEF_MAX_BURST = 4;

    typedef enum logic {
        ARB_IDLE,
        ARB_BURST
    } arb_state_t;

    // Successor of a round-robin index, wrapping at num_req (any value, not only powers of 2).
    function automatic logic [31:0] next_rr_owner(input logic [31:0] cur, input logic [31:0] num_req);
        return (cur + 32'd1 >= num_req) ? 32'd0 : cur + 32'd1;
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: finds the first asserted request strictly
// after last_owner_i, wrapping modulo NUM_REQ.
module rr_priority_picker
    import fifo_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = DEF_NUM_REQ,
    localparam int unsigned OW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [OW-1:0]      last_owner_i,
    output logic               found_o,
    output logic [OW-1:0]      owner_o
);

    logic [OW-1:0] idx;

    // NOTE: every variable written here gets a default first, otherwise paths
    // that skip an assignment would infer a latch.
    always_comb begin
        found_o = 1'b0;
        owner_o = '0;
        idx     = last_owner_i;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = OW'(next_rr_owner(32'(idx), NUM_REQ));
            if (!found_o && req_i[idx]) begin
                found_o = 1'b1;
                owner_o = idx;
            end
        end
    end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing the async FIFO write port among NUM_REQ producers,
// with per-owner burst lock of up to MAX_BURST words and full back-pressure.
module fifo_write_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int unsigned BITSIZE   = DEF_BITSIZE,
    parameter int unsigned NUM_REQ   = DEF_NUM_REQ,
    parameter int unsigned MAX_BURST = DEF_MAX_BURST
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*BITSIZE-1:0] req_data,
    output logic [NUM_REQ-1:0]         ack,
    output logic [NUM_REQ-1:0]         grant,
    output logic                       busy,
    input  logic                       full,
    output logic                       w_enable,
    output logic [BITSIZE-1:0]         wdata
);

    localparam int unsigned OW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CW = $clog2(MAX_BURST + 1);

    arb_state_t    state_q, state_d;
    logic [OW-1:0] owner_q, owner_d;
    logic [OW-1:0] last_owner_q, last_owner_d;
    logic [CW-1:0] burst_cnt_q, burst_cnt_d;

    logic               pick_found;
    logic [OW-1:0]      pick_owner;
    logic [BITSIZE-1:0] owner_data;

    rr_priority_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_picker (
        .req_i        (req),
        .last_owner_i (last_owner_q),
        .found_o      (pick_found),
        .owner_o      (pick_owner)
    );

    always_comb begin
        owner_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (owner_q == OW'(i)) begin
                owner_data = req_data[i*BITSIZE +: BITSIZE];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        burst_cnt_d  = burst_cnt_q;
        w_enable     = 1'b0;
        ack          = '0;
        grant        = '0;
        busy         = 1'b0;
        wdata        = '0;

        case (state_q)
            ARB_IDLE: begin
                if (pick_found) begin
                    owner_d     = pick_owner;
                    burst_cnt_d = '0;
                    state_d     = ARB_BURST;
                end
            end
            ARB_BURST: begin
                busy           = 1'b1;
                grant[owner_q] = 1'b1;
                wdata          = owner_data;
                // A dropped request ends the burst even while the FIFO is full.
                if (!req[owner_q]) begin
                    state_d      = ARB_IDLE;
                    last_owner_d = owner_q;
                end else if (!full) begin
                    w_enable     = 1'b1;
                    ack[owner_q] = 1'b1;
                    burst_cnt_d  = burst_cnt_q + 1'b1;
                    if (burst_cnt_q == CW'(MAX_BURST - 1)) begin
                        state_d      = ARB_IDLE;
                        last_owner_d = owner_q;
                    end
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its next value from the same pre-edge snapshot.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ARB_IDLE;
            owner_q      <= '0;
            last_owner_q <= OW'(NUM_REQ - 1);
            burst_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            burst_cnt_q  <= burst_cnt_d;
        end
    end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Scoreboard bench for fifo_write_arbiter: directed requester traffic with
// hand-computed per-cycle grant/ack patterns and expected write order.
module tb_fifo_write_arbiter;

    localparam int BW = 8;
    localparam int NR = 4;

    logic             clk = 1'b0;
    logic             reset_n;
    logic [NR-1:0]    req;
    logic [NR*BW-1:0] req_data;
    logic [NR-1:0]    ack;
    logic [NR-1:0]    grant;
    logic             busy;
    logic             full;
    logic             w_enable;
    logic [BW-1:0]    wdata;

    always #5 clk = ~clk;

    fifo_write_arbiter #(
        .BITSIZE   (BW),
        .NUM_REQ   (NR),
        .MAX_BURST (4)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .req      (req),
        .req_data (req_data),
        .ack      (ack),
        .grant    (grant),
        .busy     (busy),
        .full     (full),
        .w_enable (w_enable),
        .wdata    (wdata)
    );

    int    n_cmp = 0;
    int    n_err = 0;
    string phase = "init";

    typedef struct packed {
        logic [NR-1:0] ack;
        logic [BW-1:0] data;
    } exp_t;

    exp_t    exp_q[$];
    exp_t    exp_e;
    logic [BW-1:0] src_mem [NR][16];
    int      head [NR];
    int      tail [NR];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s/%s: got 0x%0h, expected 0x%0h at %0t", phase, name, act, exp, $time);
        end
    endtask

    task automatic load(input int i, input logic [BW-1:0] d);
        src_mem[i][tail[i]] = d;
        tail[i]++;
    endtask

    task automatic expect_word(input int i, input logic [BW-1:0] d);
        exp_t e;
        e.ack  = NR'(1) << i;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic drive();
        for (int i = 0; i < NR; i++) begin
            req[i] = (head[i] < tail[i]);
            req_data[i*BW +: BW] = req[i] ? src_mem[i][head[i]] : '0;
        end
    endtask

    // One clock: check outputs at the falling edge, then retire acked words.
    task automatic cycle(input logic [NR-1:0] eg, input logic [NR-1:0] ea);
        logic [NR-1:0] ack_s;
        @(negedge clk);
        ack_s = ack;
        check("grant", 32'(grant), 32'(eg));
        check("ack", 32'(ack), 32'(ea));
        check("busy", 32'(busy), 32'(eg != '0));
        check("w_enable", 32'(w_enable), 32'(ea != '0));
        @(posedge clk);
        #1;
        for (int i = 0; i < NR; i++) begin
            if (ack_s[i]) head[i]++;
        end
        drive();
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        cycle('0, '0);
        cycle('0, '0);
        reset_n = 1'b1;
    endtask

    always @(negedge clk) begin
        if (reset_n && w_enable) begin
            check("wen_while_full", 32'(full), 32'd0);
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL %s/sb_unexpected: got write 0x%0h ack 0x%0h, expected no write", phase, wdata, ack);
            end else begin
                exp_e = exp_q.pop_front();
                check("sb_ack", 32'(ack), 32'(exp_e.ack));
                check("sb_wdata", 32'(wdata), 32'(exp_e.data));
            end
        end
    end

    initial begin
        reset_n  = 1'b0;
        full     = 1'b0;
        req      = '0;
        req_data = '0;
        for (int i = 0; i < NR; i++) begin
            head[i] = 0;
            tail[i] = 0;
        end

        // Reset with all requesters active, then contention round-robin.
        phase = "reset_contention";
        for (int k = 0; k < 8; k++) load(0, 8'(8'h10 + k));
        for (int i = 1; i < NR; i++) begin
            for (int k = 0; k < 4; k++) load(i, 8'(8'h10 * (i + 1) + k));
        end
        drive();
        for (int c = 0; c < 3; c++) cycle('0, '0);
        begin
            int o_seq [5] = '{0, 1, 2, 3, 0};
            for (int b = 0; b < 5; b++) begin
                for (int k = 0; k < 4; k++) begin
                    expect_word(o_seq[b], 8'(8'h10 * (o_seq[b] + 1) + ((b == 4) ? k + 4 : k)));
                end
            end
            reset_n = 1'b1;
            for (int b = 0; b < 5; b++) begin
                cycle('0, '0);
                for (int k = 0; k < 4; k++) cycle(NR'(1) << o_seq[b], NR'(1) << o_seq[b]);
            end
            cycle('0, '0);
        end
        check("drained", 32'(exp_q.size()), 32'd0);

        // Single requester, six words: burst of four, re-arbitrate, two more.
        phase = "single_burst";
        do_reset();
        for (int k = 0; k < 6; k++) begin
            load(1, 8'(8'hA0 + k));
            expect_word(1, 8'(8'hA0 + k));
        end
        drive();
        cycle('0, '0);
        for (int k = 0; k < 4; k++) cycle(4'b0010, 4'b0010);
        cycle('0, '0);
        cycle(4'b0010, 4'b0010);
        cycle(4'b0010, 4'b0010);
        cycle(4'b0010, '0);
        cycle('0, '0);
        check("drained", 32'(exp_q.size()), 32'd0);

        // FIFO full for three cycles after the second word.
        phase = "full_stall";
        do_reset();
        for (int k = 0; k < 4; k++) begin
            load(2, 8'(8'hB0 + k));
            expect_word(2, 8'(8'hB0 + k));
        end
        drive();
        cycle('0, '0);
        cycle(4'b0100, 4'b0100);
        cycle(4'b0100, 4'b0100);
        full = 1'b1;
        for (int c = 0; c < 3; c++) cycle(4'b0100, '0);
        full = 1'b0;
        cycle(4'b0100, 4'b0100);
        cycle(4'b0100, 4'b0100);
        cycle('0, '0);
        check("drained", 32'(exp_q.size()), 32'd0);

        // Owner 1 drops after one word; requester 2 follows.
        phase = "early_drop";
        do_reset();
        load(1, 8'hC1);
        load(2, 8'hC2);
        load(2, 8'hC3);
        expect_word(1, 8'hC1);
        expect_word(2, 8'hC2);
        expect_word(2, 8'hC3);
        drive();
        cycle('0, '0);
        cycle(4'b0010, 4'b0010);
        cycle(4'b0010, '0);
        cycle('0, '0);
        cycle(4'b0100, 4'b0100);
        cycle(4'b0100, 4'b0100);
        cycle(4'b0100, '0);
        cycle('0, '0);
        check("drained", 32'(exp_q.size()), 32'd0);

        // Asynchronous reset in the middle of owner 3's burst.
        phase = "mid_burst_reset";
        do_reset();
        for (int k = 0; k < 6; k++) load(3, 8'(8'hD0 + k));
        expect_word(3, 8'hD0);
        expect_word(3, 8'hD1);
        drive();
        cycle('0, '0);
        cycle(4'b1000, 4'b1000);
        cycle(4'b1000, 4'b1000);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_w_enable", 32'(w_enable), 32'd0);
        check("async_ack", 32'(ack), 32'd0);
        check("async_grant", 32'(grant), 32'd0);
        check("async_busy", 32'(busy), 32'd0);
        check("drained_pre", 32'(exp_q.size()), 32'd0);
        load(0, 8'hE0);
        load(0, 8'hE1);
        expect_word(0, 8'hE0);
        expect_word(0, 8'hE1);
        for (int k = 2; k < 6; k++) expect_word(3, 8'(8'hD0 + k));
        drive();
        cycle('0, '0);
        cycle('0, '0);
        reset_n = 1'b1;
        cycle('0, '0);
        cycle(4'b0001, 4'b0001);
        cycle(4'b0001, 4'b0001);
        cycle(4'b0001, '0);
        cycle('0, '0);
        for (int k = 0; k < 4; k++) cycle(4'b1000, 4'b1000);
        cycle('0, '0);
        check("drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
